// File: rtl/inst_loader.sv
// inst_loader: fills instruction memory from a counted big-endian byte stream and releases the core via lock
module inst_loader #(
    parameter int INST_DEPTH = 64,
    parameter int ADDR_W     = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              lock,
    output logic              overflow
);
    typedef enum logic [2:0] {CNT_HI, CNT_LO, DATA, WRITE, DONE} state_t;
    localparam logic [15:0] DEPTH = 16'(INST_DEPTH);
    state_t      r_state;
    logic [15:0] r_count;
    logic [15:0] r_widx;
    logic [1:0]  r_bidx;
    logic [23:0] r_asm;
    logic        w_xfer;
    logic [15:0] w_widx_nxt;
    logic        w_in_range;
    always_comb begin
        byte_ready = !rst && (r_state == CNT_HI || r_state == CNT_LO || r_state == DATA);
        w_xfer     = byte_valid && byte_ready;
        w_widx_nxt = r_widx + 16'd1;
        w_in_range = r_widx < DEPTH;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= CNT_HI;
            r_count    <= '0;
            r_widx     <= '0;
            r_bidx     <= '0;
            r_asm      <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            lock       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            case (r_state)
                CNT_HI: if (w_xfer) begin
                    r_count[15:8] <= byte_data;
                    r_state       <= CNT_LO;
                end
                CNT_LO: if (w_xfer) begin
                    r_count[7:0] <= byte_data;
                    r_widx       <= '0;
                    r_bidx       <= '0;
                    // an empty image releases the core immediately
                    r_state      <= ({r_count[15:8], byte_data} == 16'd0) ? DONE : DATA;
                    lock         <= ({r_count[15:8], byte_data} == 16'd0);
                end
                DATA: if (w_xfer) begin
                    r_asm  <= {r_asm[15:0], byte_data};
                    r_bidx <= r_bidx + 2'd1;
                    if (r_bidx == 2'd3) begin
                        imem_wdata <= {r_asm, byte_data};
                        imem_addr  <= r_widx[ADDR_W-1:0];
                        imem_we    <= w_in_range;
                        overflow   <= overflow | !w_in_range;
                        r_state    <= WRITE;
                    end
                end
                WRITE: begin
                    imem_we <= 1'b0;
                    r_widx  <= w_widx_nxt;
                    r_state <= (w_widx_nxt == r_count) ? DONE : DATA;
                    lock    <= (w_widx_nxt == r_count);
                end
                DONE: if (reload) begin
                    lock     <= 1'b0;
                    overflow <= 1'b0;
                    r_state  <= CNT_HI;
                end
                default: r_state <= CNT_HI;
            endcase
        end
    end
endmodule

// File: tb/tb_inst_loader.sv
// tb_inst_loader: random-gap byte streams checked every cycle against a stream-level loader model
module tb_inst_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        reload = 1'b0;
    logic        byte_ready, imem_we, lock, overflow;
    logic [5:0]  imem_addr;
    logic [31:0] imem_wdata;

    inst_loader #(.INST_DEPTH(64), .ADDR_W(6)) dut (
        .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready), .reload(reload), .imem_we(imem_we),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .lock(lock), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic        m_done, m_pend, m_lock, m_ovf, m_we;
    logic [5:0]  m_addr;
    logic [31:0] m_wdata, m_asm;
    int          m_bytes, m_n, m_w;
    logic [31:0] m_mem [64];
    logic [31:0] d_mem [64];
    int          d_writes = 0;

    initial for (int i = 0; i < 64; i++) begin m_mem[i] = '0; d_mem[i] = '0; end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic m_ready();
        return !rst && !m_pend && !m_done;
    endfunction

    // Stream-level model: byte position in the image decides what each accepted byte means
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_done = 0; m_pend = 0; m_lock = 0; m_ovf = 0; m_we = 0;
            m_addr = '0; m_wdata = '0; m_asm = '0; m_bytes = 0; m_n = 0; m_w = 0;
        end else if (m_done) begin
            if (reload) begin m_done = 0; m_lock = 0; m_ovf = 0; m_bytes = 0; end
        end else if (m_pend) begin
            m_we = 0; m_pend = 0; m_w++;
            if (m_w == m_n) begin m_done = 1; m_lock = 1; end
        end else if (byte_valid) begin
            if (m_bytes == 0) m_n = int'(byte_data) << 8;
            else if (m_bytes == 1) begin
                m_n = m_n | int'(byte_data); m_w = 0;
                if (m_n == 0) begin m_done = 1; m_lock = 1; end
            end else begin
                m_asm = {m_asm[23:0], byte_data};
                if ((m_bytes - 2) % 4 == 3) begin
                    m_pend = 1; m_addr = m_w[5:0]; m_wdata = m_asm; m_we = (m_w < 64);
                    if (m_w < 64) m_mem[m_w] = m_asm; else m_ovf = 1;
                end
            end
            m_bytes++;
        end
    end

    always @(negedge clk) begin
        chk("byte_ready", 32'(byte_ready), 32'(m_ready()));
        chk("imem_we", 32'(imem_we), 32'(m_we));
        chk("imem_addr", 32'(imem_addr), 32'(m_addr));
        chk("imem_wdata", imem_wdata, m_wdata);
        chk("lock", 32'(lock), 32'(m_lock));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        if (imem_we) begin d_mem[imem_addr] = imem_wdata; d_writes++; end
    end

    task automatic send(input logic [7:0] b, input int gap);
        int g, t;
        g = (gap > 0) ? $urandom_range(gap, 0) : 0;
        repeat (g) begin @(posedge clk); #2; end
        byte_valid = 1'b1; byte_data = b; t = 0;
        @(negedge clk);
        while (!byte_ready && t < 50) begin @(negedge clk); t++; end
        if (!byte_ready) chk("send_timeout", 32'(byte_ready), 32'd1);
        @(posedge clk); #2;
        byte_valid = 1'b0;
    endtask

    task automatic send_image(input int n, input logic [31:0] words[$], input int gap);
        send(n[15:8], gap);
        send(n[7:0], gap);
        foreach (words[i]) for (int k = 3; k >= 0; k--) send(words[i][8*k +: 8], gap);
    endtask

    task automatic wait_lock(input int bound);
        int t = 0;
        while (!lock && t < bound) begin @(negedge clk); t++; end
        chk("lock_wait", 32'(lock), 32'd1);
        @(posedge clk); #2;
    endtask

    task automatic do_reload();
        reload = 1'b1;
        @(posedge clk); #2;
        reload = 1'b0;
    endtask

    initial begin
        logic [31:0] q[$];
        logic [31:0] saved;
        int w0;
        #3;
        chk("rst_lock", 32'(lock), 32'd0);
        chk("rst_we", 32'(imem_we), 32'd0);
        chk("rst_ready", 32'(byte_ready), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        q = {32'hDEADBEEF};
        send_image(1, q, 0);
        wait_lock(20);
        chk("t1_mem0", d_mem[0], 32'hDEADBEEF);
        chk("t1_writes", 32'(d_writes), 32'd1);

        do_reload();
        q = {32'h11111111, 32'h22222222, 32'h33333333};
        send_image(3, q, 3);
        wait_lock(40);
        chk("t2_mem1", d_mem[1], 32'h22222222);
        chk("t2_mem2", d_mem[2], 32'h33333333);
        chk("t2_writes", 32'(d_writes), 32'd4);

        do_reload();
        q.delete();
        send_image(0, q, 0);
        chk("t3_lock", 32'(lock), 32'd1);
        chk("t3_writes", 32'(d_writes), 32'd4);

        do_reload();
        q.delete();
        for (int i = 0; i < 65; i++) q.push_back($urandom);
        send_image(65, q, 1);
        wait_lock(100);
        chk("t4_ovf", 32'(overflow), 32'd1);
        chk("t4_writes", 32'(d_writes), 32'd68);
        chk("t4_mem63", d_mem[63], q[63]);

        do_reload();
        saved = d_mem[1];
        w0 = d_writes;
        send(8'h00, 0); send(8'h02, 0);
        for (int k = 0; k < 4; k++) send(8'hA0 + 8'(k), 0);
        send(8'h55, 0); send(8'h66, 0);
        rst = 1'b1;
        #1 chk("t5_lock_rst", 32'(lock), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        q = {32'hCAFEF00D};
        send_image(1, q, 2);
        wait_lock(30);
        chk("t5_mem0", d_mem[0], 32'hCAFEF00D);
        chk("t5_mem1", d_mem[1], saved);
        chk("t5_writes", 32'(d_writes), 32'(w0 + 2));

        chk("t6_ovf_before", 32'(overflow), 32'd0);
        do_reload();
        chk("t6_lock", 32'(lock), 32'd0);
        chk("t6_ready", 32'(byte_ready), 32'd1);
        q.delete();
        for (int i = 0; i < 5; i++) q.push_back($urandom);
        send_image(5, q, 2);
        wait_lock(40);
        chk("t6_mem4", d_mem[4], q[4]);
        for (int i = 0; i < 64; i++) chk("final_mem", d_mem[i], m_mem[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
